// File: rtl/screen_mem_arbiter.sv
// Single-SRAM arbiter: video screen fetches run in fixed 3-cycle beats, and CPU
// accesses are slotted in only at beat boundaries, with alternating fairness.
//   state | meaning
//   IDLE  | bus parked, arbitrate between video and CPU
//   VID   | video beat in progress, cyc 0..2, byte captured at cyc 1
//   CPU   | CPU read/write, cyc 0..2, ack issued on leaving
`timescale 1ns/1ps
module screen_mem_arbiter #(
    parameter int SRAM_AW    = 19,
    parameter int SCR_PAGE_A = 5,
    parameter int SCR_PAGE_B = 7
) (
    input  logic               clk28,
    input  logic               rst,
    input  logic               screen_page,
    output logic               read_allow,
    input  logic               read_req,
    input  logic               read_req_next,
    input  logic [14:0]        read_req_addr,
    output logic [7:0]         read_data,
    input  logic               cpu_req,
    input  logic               cpu_wr,
    input  logic [SRAM_AW-1:0] cpu_addr,
    input  logic [7:0]         cpu_wdata,
    output logic [7:0]         cpu_rdata,
    output logic               cpu_ack,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [7:0]         sram_dq_in,
    output logic [7:0]         sram_dq_out,
    output logic               sram_dq_oe,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    localparam int PW = SRAM_AW - 14;
    localparam logic [PW-1:0] PAGE_A = SCR_PAGE_A[PW-1:0];
    localparam logic [PW-1:0] PAGE_B = SCR_PAGE_B[PW-1:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VID  = 2'd1,
        ST_CPU  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           cyc_q, cyc_d;
    logic                 cpu_last_q, cpu_last_d;
    logic                 page_q, page_d;
    logic                 cpu_wr_q, cpu_wr_d;
    logic [SRAM_AW-1:0]   cpu_addr_q, cpu_addr_d;
    logic [7:0]           cpu_wdata_q, cpu_wdata_d;
    logic [7:0]           read_data_q, read_data_d;
    logic [7:0]           cpu_rdata_q, cpu_rdata_d;
    logic                 cpu_ack_q, cpu_ack_d;
    logic [SRAM_AW-1:0]   sram_addr_q, sram_addr_d;
    logic [7:0]           sram_dq_out_q, sram_dq_out_d;
    logic                 sram_dq_oe_q, sram_dq_oe_d;
    logic                 sram_oe_n_q, sram_oe_n_d;
    logic                 sram_we_n_q, sram_we_n_d;

    // The registered request and the top address bit carry no information here.
    logic unused_inputs;
    assign unused_inputs = ^{read_req, read_req_addr[14]};

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cyc_q         <= '0;
            cpu_last_q    <= 1'b0;
            page_q        <= 1'b0;
            cpu_wr_q      <= 1'b0;
            cpu_addr_q    <= '0;
            cpu_wdata_q   <= '0;
            read_data_q   <= '0;
            cpu_rdata_q   <= '0;
            cpu_ack_q     <= 1'b0;
            sram_addr_q   <= '0;
            sram_dq_out_q <= '0;
            sram_dq_oe_q  <= 1'b0;
            sram_oe_n_q   <= 1'b1;
            sram_we_n_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            cpu_last_q    <= cpu_last_d;
            page_q        <= page_d;
            cpu_wr_q      <= cpu_wr_d;
            cpu_addr_q    <= cpu_addr_d;
            cpu_wdata_q   <= cpu_wdata_d;
            read_data_q   <= read_data_d;
            cpu_rdata_q   <= cpu_rdata_d;
            cpu_ack_q     <= cpu_ack_d;
            sram_addr_q   <= sram_addr_d;
            sram_dq_out_q <= sram_dq_out_d;
            sram_dq_oe_q  <= sram_dq_oe_d;
            sram_oe_n_q   <= sram_oe_n_d;
            sram_we_n_q   <= sram_we_n_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        cpu_last_d  = cpu_last_q;
        page_d      = page_q;
        cpu_wr_d    = cpu_wr_q;
        cpu_addr_d  = cpu_addr_q;
        cpu_wdata_d = cpu_wdata_q;
        read_data_d = read_data_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ack_d   = 1'b0;
        read_allow  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Video wins a tie only when the CPU had the previous slot.
                read_allow = !(cpu_req && !cpu_last_q);
                if (read_req_next && read_allow) begin
                    state_d    = ST_VID;
                    cyc_d      = 2'd0;
                    page_d     = screen_page;
                    cpu_last_d = 1'b0;
                end else if (cpu_req) begin
                    state_d     = ST_CPU;
                    cyc_d       = 2'd0;
                    cpu_wr_d    = cpu_wr;
                    cpu_addr_d  = cpu_addr;
                    cpu_wdata_d = cpu_wdata;
                end
            end
            ST_VID: begin
                read_allow = !(cyc_q == 2'd2 && cpu_req);
                if (cyc_q == 2'd2 && cpu_req) begin
                    state_d     = ST_CPU;
                    cyc_d       = 2'd0;
                    cpu_wr_d    = cpu_wr;
                    cpu_addr_d  = cpu_addr;
                    cpu_wdata_d = cpu_wdata;
                end else if (!read_req_next) begin
                    state_d = ST_IDLE;
                    cyc_d   = 2'd0;
                end else begin
                    if (cyc_q == 2'd1) begin
                        read_data_d = sram_dq_in;
                    end
                    cyc_d = (cyc_q == 2'd2) ? 2'd0 : cyc_q + 2'd1;
                end
            end
            ST_CPU: begin
                if (cyc_q == 2'd2) begin
                    if (!cpu_wr_q) begin
                        cpu_rdata_d = sram_dq_in;
                    end
                    cpu_ack_d  = 1'b1;
                    cpu_last_d = 1'b1;
                    state_d    = ST_IDLE;
                    cyc_d      = 2'd0;
                end else begin
                    cyc_d = cyc_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 2'd0;
            end
        endcase
    end

    // SRAM pins are registered from the upcoming state so they line up with cyc.
    always_comb begin
        sram_addr_d   = sram_addr_q;
        sram_dq_out_d = sram_dq_out_q;
        sram_dq_oe_d  = 1'b0;
        sram_oe_n_d   = 1'b1;
        sram_we_n_d   = 1'b1;

        case (state_d)
            ST_VID: begin
                sram_addr_d = {(page_d ? PAGE_B : PAGE_A), read_req_addr[13:0]};
                sram_oe_n_d = 1'b0;
            end
            ST_CPU: begin
                sram_addr_d = cpu_addr_d;
                if (cpu_wr_d) begin
                    sram_dq_oe_d  = 1'b1;
                    sram_dq_out_d = cpu_wdata_d;
                    sram_we_n_d   = (cyc_d != 2'd1);
                end else begin
                    sram_oe_n_d = 1'b0;
                end
            end
            default: begin
                sram_dq_oe_d = 1'b0;
            end
        endcase
    end

    assign read_data   = read_data_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_ack     = cpu_ack_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = sram_dq_out_q;
    assign sram_dq_oe  = sram_dq_oe_q;
    assign sram_oe_n   = sram_oe_n_q;
    assign sram_we_n   = sram_we_n_q;

endmodule

// File: tb/tb_screen_mem_arbiter.sv
// Scoreboard bench for screen_mem_arbiter: stimulus queues expected CPU acks,
// SRAM write strobes and video bytes; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_screen_mem_arbiter;

    localparam int AW = 19;

    logic          clk28 = 1'b0;
    logic          rst;
    logic          screen_page;
    logic          read_allow;
    logic          read_req;
    logic          read_req_next;
    logic [14:0]   read_req_addr;
    logic [7:0]    read_data;
    logic          cpu_req;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic [7:0]    cpu_rdata;
    logic          cpu_ack;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_dq_in;
    logic [7:0]    sram_dq_out;
    logic          sram_dq_oe;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic          vid_want;

    screen_mem_arbiter #(.SRAM_AW(AW), .SCR_PAGE_A(5), .SCR_PAGE_B(7)) dut (
        .clk28(clk28), .rst(rst), .screen_page(screen_page),
        .read_allow(read_allow), .read_req(read_req), .read_req_next(read_req_next),
        .read_req_addr(read_req_addr), .read_data(read_data),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    always #5 clk28 = ~clk28;

    // Video fetcher: wants data, but only asks while allowed.
    assign read_req_next = vid_want & read_allow;
    always @(posedge clk28) read_req <= read_req_next;

    // SRAM: unwritten locations return addr[7:0].
    logic [7:0] mem      [0:(1<<AW)-1];
    bit         wr_valid [0:(1<<AW)-1];
    assign sram_dq_in = wr_valid[sram_addr] ? mem[sram_addr] : sram_addr[7:0];
    always @(posedge clk28) begin
        if (!sram_we_n) begin
            mem[sram_addr]      <= sram_dq_out;
            wr_valid[sram_addr] <= 1'b1;
        end
    end

    int cyc_cnt = 0;
    always @(posedge clk28) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [7:0] rdata;
        bit         chk_rdata;
        int         max_lat;
        bit         exact;
        int         req_cyc;
    } cpu_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } bus_exp_t;

    cpu_exp_t cpu_q[$];
    bus_exp_t wr_q[$];
    bus_exp_t vid_q[$];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // Monitor
    int       ack_cnt    = 0;
    int       turn_viol  = 0;
    int       vcnt       = 0;
    bit       prev_we_low = 1'b0;
    cpu_exp_t mc;
    bus_exp_t mb;
    int       lat;

    always @(negedge clk28) begin
        if (!rst) begin
            if (sram_dq_oe && !sram_oe_n) turn_viol++;
            if (cpu_ack) begin
                ack_cnt++;
                check("ack_expected", 32'(cpu_q.size() > 0), 1);
                if (cpu_q.size() > 0) begin
                    mc  = cpu_q.pop_front();
                    lat = cyc_cnt - mc.req_cyc;
                    if (mc.chk_rdata) check("cpu_rdata", 32'(cpu_rdata), 32'(mc.rdata));
                    if (mc.exact) check("ack_latency", 32'(lat), 32'(mc.max_lat));
                    else check("ack_latency_max", 32'(lat <= mc.max_lat), 1);
                end
            end
            if (!sram_we_n) begin
                check("wr_expected", 32'(wr_q.size() > 0), 1);
                check("we_n_single", 32'(prev_we_low), 0);
                check("wr_dq_oe", 32'(sram_dq_oe), 1);
                check("wr_oe_n", 32'(sram_oe_n), 1);
                if (wr_q.size() > 0) begin
                    mb = wr_q.pop_front();
                    check("wr_addr", 32'(sram_addr), 32'(mb.addr));
                    check("wr_data", 32'(sram_dq_out), 32'(mb.data));
                end
            end
            prev_we_low = !sram_we_n;
            if (!sram_oe_n && !sram_dq_oe &&
                (sram_addr[18:14] == 5'd5 || sram_addr[18:14] == 5'd7)) vcnt++;
            else vcnt = 0;
            if (vcnt == 3) begin
                vcnt = 0;
                check("vid_expected", 32'(vid_q.size() > 0), 1);
                if (vid_q.size() > 0) begin
                    mb = vid_q.pop_front();
                    check("vid_addr", 32'(sram_addr), 32'(mb.addr));
                    check("vid_data", 32'(read_data), 32'(mb.data));
                end
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 of the ack cycle with cpu_req low.
    task automatic cpu_access(input bit wr, input logic [AW-1:0] a, input logic [7:0] d,
                              input logic [7:0] exp_rd, input bit chk, input int maxlat,
                              input bit exact);
        cpu_exp_t e;
        bus_exp_t w;
        bit got;
        e.rdata = exp_rd; e.chk_rdata = chk; e.max_lat = maxlat; e.exact = exact;
        e.req_cyc = cyc_cnt;
        cpu_q.push_back(e);
        if (wr) begin
            w.addr = a; w.data = d;
            wr_q.push_back(w);
        end
        cpu_wr = wr; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk28); #1;
            if (cpu_ack) got = 1'b1;
        end
        cpu_req = 1'b0; cpu_wr = 1'b0;
        check("cpu_ack_seen", 32'(got), 1);
    endtask

    task automatic vid_run(input bit pg, input logic [14:0] a0, input logic [14:0] a1,
                           input logic [AW-1:0] ea0, input logic [7:0] ed0,
                           input logic [AW-1:0] ea1, input logic [7:0] ed1);
        bus_exp_t v;
        v.addr = ea0; v.data = ed0; vid_q.push_back(v);
        v.addr = ea1; v.data = ed1; vid_q.push_back(v);
        screen_page = pg; read_req_addr = a0; vid_want = 1'b1;
        repeat (3) @(posedge clk28);
        #1 read_req_addr = a1;
        repeat (3) @(posedge clk28);
        #1 vid_want = 1'b0;
        @(posedge clk28); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int acks_before;
    bus_exp_t vb;

    initial begin
        rst = 1'b1; screen_page = 1'b0; read_req_addr = '0; vid_want = 1'b0;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk28);
        #1 rst = 1'b0;
        @(negedge clk28);
        check("rst_read_allow", 32'(read_allow), 1);
        check("rst_oe_n", 32'(sram_oe_n), 1);
        check("rst_we_n", 32'(sram_we_n), 1);
        check("rst_dq_oe", 32'(sram_dq_oe), 0);
        check("rst_read_data", 32'(read_data), 0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 0);
        check("rst_cpu_ack", 32'(cpu_ack), 0);
        check("rst_sram_addr", 32'(sram_addr), 0);
        check("rst_dq_out", 32'(sram_dq_out), 0);
        @(posedge clk28); #1;

        // CPU write then reads from IDLE
        cpu_access(1'b1, 19'h7FFFF, 8'hA5, 8'h00, 1'b0, 4, 1'b1);
        cpu_access(1'b0, 19'h7FFFF, 8'h00, 8'hA5, 1'b1, 4, 1'b1);
        cpu_access(1'b0, 19'h00042, 8'h00, 8'h42, 1'b1, 4, 1'b1);

        // Video beats on both screen pages
        vid_run(1'b0, 15'h1800, 15'h1AC0, 19'h15800, 8'h00, 19'h15AC0, 8'hC0);
        vid_run(1'b1, 15'h1800, 15'h1AC0, 19'h1D800, 8'h00, 19'h1DAC0, 8'hC0);

        // Tie with cpu_last=0: CPU wins
        screen_page = 1'b0; read_req_addr = 15'h0555; vid_want = 1'b1;
        fork
            cpu_access(1'b0, 19'h7FFFF, 8'h00, 8'hA5, 1'b1, 4, 1'b1);
            begin @(negedge clk28); check("tie_cpu_allow", 32'(read_allow), 0); end
        join
        vid_want = 1'b0;
        @(posedge clk28); #1;

        // CPU request raised during VID cyc0
        screen_page = 1'b0; read_req_addr = 15'h0123; vid_want = 1'b1;
        vb.addr = 19'h14123; vb.data = 8'h23; vid_q.push_back(vb);
        @(posedge clk28); #1;
        fork
            cpu_access(1'b0, 19'h7FFFF, 8'h00, 8'hA5, 1'b1, 7, 1'b0);
            begin
                repeat (2) @(posedge clk28);
                @(negedge clk28);
                check("vid_cyc2_allow", 32'(read_allow), 0);
            end
        join
        vid_want = 1'b0;
        @(posedge clk28); #1;

        // Tie right after a CPU slot: video wins
        screen_page = 1'b1; read_req_addr = 15'h2345; vid_want = 1'b1;
        vb.addr = 19'h1E345; vb.data = 8'h45; vid_q.push_back(vb);
        fork
            cpu_access(1'b1, 19'h00010, 8'h3C, 8'h00, 1'b0, 7, 1'b0);
            begin @(negedge clk28); check("tie_vid_allow", 32'(read_allow), 1); end
        join
        vid_want = 1'b0;
        cpu_access(1'b0, 19'h00010, 8'h00, 8'h3C, 1'b1, 4, 1'b1);

        // Reset during write cyc1
        @(posedge clk28); #1;
        cpu_wr = 1'b1; cpu_addr = 19'h00123; cpu_wdata = 8'h5A; cpu_req = 1'b1;
        @(posedge clk28);
        @(posedge clk28); #1;
        check("pre_rst_we_n", 32'(sram_we_n), 0);
        acks_before = ack_cnt;
        rst = 1'b1;
        #1;
        check("rst_abort_we_n", 32'(sram_we_n), 1);
        check("rst_abort_dq_oe", 32'(sram_dq_oe), 0);
        cpu_req = 1'b0; cpu_wr = 1'b0;
        repeat (2) @(posedge clk28);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk28);
        @(negedge clk28);
        check("rst_abort_no_ack", 32'(ack_cnt), 32'(acks_before));
        check("post_rst_allow", 32'(read_allow), 1);
        check("post_rst_oe_n", 32'(sram_oe_n), 1);
        @(posedge clk28); #1;
        cpu_access(1'b0, 19'h00123, 8'h00, 8'h23, 1'b1, 4, 1'b1);
        cpu_access(1'b0, 19'h7FFFF, 8'h00, 8'hA5, 1'b1, 4, 1'b1);

        for (int i = 0; i < 20 && (cpu_q.size() + wr_q.size() + vid_q.size()) > 0; i++)
            @(posedge clk28);
        repeat (2) @(posedge clk28);
        check("cpu_q_drained", 32'(cpu_q.size()), 0);
        check("wr_q_drained", 32'(wr_q.size()), 0);
        check("vid_q_drained", 32'(vid_q.size()), 0);
        check("bus_turnaround", 32'(turn_viol), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/screen_mem_arbiter.md
Name: screen_mem_arbiter

Overview:
- Memory-side responder for the video fetch interface (read_allow / read_req / read_req_next / read_req_addr / read_data).
- Arbitrates one external 8-bit SRAM between video screen fetches and CPU accesses.
- Maps 15-bit screen addresses into the active 16K screen page.
- Video fetches run in 3-cycle beats. The CPU is granted slots only at beat boundaries, so video fetch timing stays deterministic.

Parameters:
- SRAM_AW, 19, SRAM address width (512K, 32 pages of 16K).
- SCR_PAGE_A, 5, page holding the normal screen.
- SCR_PAGE_B, 7, page holding the shadow screen.

Ports:
- clk28  in  1  system clock, 28 MHz.
- rst  in  1  asynchronous reset, active-high.
- screen_page  in  1  0 selects SCR_PAGE_A, 1 selects SCR_PAGE_B; sampled on entry to VID.
- read_allow  out  1  combinational grant to the video fetcher.
- read_req  in  1  registered fetch request from video.
- read_req_next  in  1  combinational next-cycle fetch request from video.
- read_req_addr  in  15  screen byte address; bits [13:0] used.
- read_data  out  8  fetched screen byte.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_wr  in  1  1 = write.
- cpu_addr  in  SRAM_AW  CPU physical address.
- cpu_wdata  in  8  write data.
- cpu_rdata  out  8  read data; valid with cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse.
- sram_addr  out  SRAM_AW  SRAM address.
- sram_dq_in  in  8  SRAM data in.
- sram_dq_out  out  8  SRAM data out.
- sram_dq_oe  out  1  data bus drive enable.
- sram_oe_n  out  1  SRAM output enable, active-low.
- sram_we_n  out  1  SRAM write enable, active-low.

Behaviour:
- Reset values (immediate, async):
  - state=IDLE, cyc=0, cpu_last=0, read_data=0, cpu_rdata=0, cpu_ack=0.
  - sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_oe_n=1, sram_we_n=1.
- Reset mid-access aborts the access: we_n returns high with no glitch low, and no ack is issued.
- States and counter: IDLE, VID, CPU; cyc is 2 bits, counting 0,1,2 per beat.
- read_allow:
  - IDLE: !(cpu_req && !cpu_last).
  - VID: !(cyc==2 && cpu_req).
  - CPU: 0.
- IDLE transitions:
  - read_req_next && read_allow: go to VID, cyc=0, latch screen_page.
  - Else cpu_req: go to CPU, cyc=0, latch cpu_wr, cpu_addr and cpu_wdata.
  - Simultaneous requests: CPU wins unless cpu_last=1, in which case video wins.
  - cpu_last is set on CPU completion and cleared on VID entry. This gives alternating fairness and no starvation.
- VID:
  - sram_addr = {page(5b), read_req_addr[13:0]}, tracked combinationally-registered each cycle so address step changes from the video are followed.
  - sram_oe_n=0, sram_dq_oe=0.
  - At cyc==1: read_data <= sram_dq_in. read_data holds otherwise, so it is stable throughout cyc==2.
  - cyc wraps 2 to 0 while read_req_next stays high.
  - At cyc==2, cpu_req preempts: go to CPU (read_allow is already 0, so the video drops read_req_next).
  - read_req_next low in any cycle: go to IDLE, cyc=0. A partial beat is discarded and read_data is not updated.
- CPU read:
  - cyc0..2: sram_addr=cpu_addr, oe_n=0.
  - At cyc2: cpu_rdata <= sram_dq_in and cpu_ack=1 next cycle; go to IDLE.
- CPU write:
  - cyc0..2: dq_oe=1, dq_out=cpu_wdata, oe_n=1.
  - we_n=0 only during cyc1, giving address/data setup and hold of one clock each.
  - Ack and return to IDLE as for a read.
- cpu_req must drop the cycle after cpu_ack. A re-assertion is treated as a new access.
- Latency:
  - CPU access, from IDLE: 4 cycles request-to-ack.
  - CPU access, worst case behind video: 3 cycles wait plus 4.
  - First video byte: valid 2 cycles after VID entry.
- Bus turnaround: dq_oe is never 1 in a cycle where oe_n=0.

Test Plan:
- Reset, then idle with cpu_req=0 -> read_allow=1, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0, all data outputs 0.
- screen_page=0, read_req_next held 6 cycles, read_req_addr=0x1800 then 0x1AC0, SRAM model returns addr[7:0]:
  - sram_addr is 0x15800 then 0x15AC0.
  - read_data is 0x00 then 0xC0, each valid in the cyc==2 cycle.
  - With screen_page=1 the addresses become 0x1D800 and 0x1DAC0.
- cpu_req write to 0x7FFFF with data 0xA5 from IDLE:
  - we_n is low exactly one cycle with dq_out=0xA5.
  - cpu_ack 4 cycles after request.
  - A subsequent read of 0x7FFFF returns cpu_rdata=0xA5.
- cpu_req raised during VID cyc0:
  - Video beat completes with read_allow=0 at cyc2.
  - CPU access runs; the next tie in IDLE goes to video (cpu_last).
  - CPU ack no later than 7 cycles after request.
- Simultaneous cpu_req and read_req_next in IDLE with cpu_last=0 -> CPU granted, read_allow=0 in that cycle.
- rst asserted during CPU write cyc1 -> we_n=1 and dq_oe=0 immediately, no cpu_ack; state is IDLE after reset release.
